// File: rtl/car_sensor_conditioner.sv
// Loop-detector debounce and emergency-request stretcher ahead of the traffic-light controller.
// Define STUCK_DETECT_EN to add the sticky stuck-sensor detector (STUCK_CYCLES / STUCK_W parameters).
module car_sensor_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES  = 4,
   parameter int unsigned HOLD_CYCLES      = 8,
   parameter int unsigned EMERG_MIN_CYCLES = 16,
   parameter int unsigned CNT_W            = 5
`ifdef STUCK_DETECT_EN
   ,
   parameter int unsigned STUCK_CYCLES     = 200,
   parameter int unsigned STUCK_W          = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_car,
   input  logic raw_emerg,
   output logic car_present,
   output logic emergeny,
   output logic sensor_fault
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] EMIN      = CNT_W'(EMERG_MIN_CYCLES);

   typedef enum logic [1:0] {IDLE, ARMING, PRESENT, HOLD} car_state_e;
   typedef enum logic {E_IDLE, E_ACTIVE} em_state_e;

   logic car_meta_q, car_sync_q, emerg_meta_q, emerg_sync_q;
   logic sc, se;

   car_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   em_state_e        estate_q, estate_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;
   logic             car_fsm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         car_meta_q   <= 1'b0;
         car_sync_q   <= 1'b0;
         emerg_meta_q <= 1'b0;
         emerg_sync_q <= 1'b0;
      end else begin
         car_meta_q   <= raw_car;
         car_sync_q   <= car_meta_q;
         emerg_meta_q <= raw_emerg;
         emerg_sync_q <= emerg_meta_q;
      end
   end

   assign sc = car_sync_q;
   assign se = emerg_sync_q;

   // Car FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Car FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (sc) begin
               cnt_d   = CNT_W'(1);
               state_d = (DEBOUNCE_CYCLES == 1) ? PRESENT : ARMING;
            end
         end
         ARMING: begin
            if (!sc) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESENT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESENT: begin
            if (!sc) begin
               cnt_d   = CNT_W'(1);
               state_d = (HOLD_CYCLES == 1) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (sc) begin
               state_d = PRESENT;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Car FSM: output decode
   always_comb begin
      car_fsm = (state_q == PRESENT) || (state_q == HOLD);
   end

   // Emergency FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estate_q <= E_IDLE;
         ecnt_q   <= '0;
      end else begin
         estate_q <= estate_d;
         ecnt_q   <= ecnt_d;
      end
   end

   // Emergency FSM: next state; ecnt saturates at the minimum on-time
   always_comb begin
      estate_d = estate_q;
      ecnt_d   = ecnt_q;
      unique case (estate_q)
         E_IDLE: begin
            if (se) begin
               estate_d = E_ACTIVE;
               ecnt_d   = CNT_W'(1);
            end
         end
         E_ACTIVE: begin
            if (ecnt_q == EMIN && !se) begin
               estate_d = E_IDLE;
            end else if (ecnt_q != EMIN) begin
               ecnt_d = ecnt_q + 1'b1;
            end
         end
         default: begin
            estate_d = E_IDLE;
            ecnt_d   = '0;
         end
      endcase
   end

   // Emergency FSM: output decode
   always_comb begin
      emergeny = (estate_q == E_ACTIVE);
   end

`ifdef STUCK_DETECT_EN
   localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

   logic [STUCK_W-1:0] stuck_q, stuck_d;
   logic               fault_q, fault_d;

   always_comb begin
      stuck_d = stuck_q;
      if (!sc) begin
         stuck_d = '0;
      end else if (stuck_q != STUCK_MAX) begin
         stuck_d = stuck_q + 1'b1;
      end
      fault_d = fault_q | (stuck_d == STUCK_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stuck_q <= '0;
         fault_q <= 1'b0;
      end else begin
         stuck_q <= stuck_d;
         fault_q <= fault_d;
      end
   end

   // A stuck loop forces car_present so both roads keep alternating on the long timer
   always_comb begin
      car_present  = car_fsm | fault_q;
      sensor_fault = fault_q;
   end
`else
   always_comb begin
      car_present  = car_fsm;
      sensor_fault = 1'b0;
   end
`endif

endmodule
